// File: rtl/cmp_share_pkg.sv
// Shared definitions for the comparator-sharing arbiter: FSM state encoding,
// default widths and the log2 helper used to size the grant index.
// Optional feature macro used by the design: CMP_SHARE_EQ_EN.
package cmp_share_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2, minimum 1 so a 2-requester index still has one bit
    function automatic int unsigned log2c(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Signed less-than built on a subtract of sign-extended operands. The extra
// top bit keeps the sign of the difference correct even when the WIDTH-bit
// subtract would overflow, so it is the overflow-corrected result directly.
module cmp_core
    import cmp_share_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;

    assign a_x = {a[WIDTH-1], a};
    assign b_x = {b[WIDTH-1], b};
    // Only the sign bit of the WIDTH+1-bit difference is needed
    assign lt  = 1'((a_x - b_x) >> WIDTH);

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around. N_REQ is a power of two so the index wraps naturally.
module rr_arb
    import cmp_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [log2c(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        grant,
    output logic [log2c(N_REQ)-1:0] idx,
    output logic                    valid
);

    localparam int unsigned IW = log2c(N_REQ);

    logic [IW-1:0] cand;

    // Scan from the pointer upward and keep the first requester found
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IW'(i);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter and sequencer sharing one signed magnitude comparator
// between N_REQ requesters. IDLE picks and latches operands, LOAD compares
// and registers the flags, RESP presents a one-cycle ack and advances the
// round-robin pointer past the served requester.
// Optional feature: define CMP_SHARE_EQ_EN to add the registered eq output.
module cmp_share_arb
    import cmp_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_bus,
    input  logic [N_REQ*WIDTH-1:0]   b_bus,
    output logic [N_REQ-1:0]         ack,
    output logic                     lt,
    output logic                     gt,
`ifdef CMP_SHARE_EQ_EN
    output logic                     eq,
`endif
    output logic [log2c(N_REQ)-1:0]  gnt_id,
    output logic                     busy
);

    localparam int unsigned IW = log2c(N_REQ);

    state_t           state;
    state_t           state_n;
    logic             load_en;
    logic             cmp_en;
    logic             done_en;

    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    gnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ack_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             lt_q;
    logic             gt_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             lt_ab;
    logic             lt_ba;

    rr_arb #(.N_REQ(N_REQ)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // a < b and b < a from the same subtractor structure; gt is the swapped case
    cmp_core #(.WIDTH(WIDTH)) u_cmp_ab (
        .a  (a_q),
        .b  (b_q),
        .lt (lt_ab)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_ba (
        .a  (b_q),
        .b  (a_q),
        .lt (lt_ba)
    );

    // Route the winning requester's operands using the one-hot grant
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                a_sel = a_bus[i*WIDTH +: WIDTH];
                b_sel = b_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-state datapath enables
    always_comb begin
        state_n = state;
        load_en = 1'b0;
        cmp_en  = 1'b0;
        done_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    load_en = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cmp_en  = 1'b1;
                state_n = ST_RESP;
            end
            ST_RESP: begin
                done_en = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand latch, compare result registers, ack pulse and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            if (load_en) begin
                a_q     <= a_sel;
                b_q     <= b_sel;
                gnt_q   <= pick_idx;
                grant_q <= pick_grant;
            end
            if (cmp_en) begin
                lt_q  <= lt_ab;
                gt_q  <= lt_ba;
                ack_q <= grant_q;
            end
            if (done_en) begin
                ack_q <= '0;
                ptr_q <= gnt_q + IW'(1);
            end
        end
    end

`ifdef CMP_SHARE_EQ_EN
    logic eq_q;

    // Equality flag registered alongside lt/gt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q <= 1'b0;
        end else if (cmp_en) begin
            eq_q <= (a_q == b_q);
        end
    end

    assign eq = eq_q;
`endif

    assign ack    = ack_q;
    assign lt     = lt_q;
    assign gt     = gt_q;
    assign gnt_id = gnt_q;
    assign busy   = (state != ST_IDLE);

endmodule

// File: doc/cmp_share_arb.md
# cmp_share_arb

Round-robin arbiter and sequencer sharing one 32-bit set-less-than/greater-than comparator between N requesters. It sits between the control units that need a magnitude compare and the single comparator datapath, which is built on the existing 32-bit add/sub unit. It accepts per-requester operand pairs under a req/ack handshake, serialises them through a three-state FSM and returns registered lt/gt flags to the granted requester.

## Interface
- N_REQ, 4, number of requesters; power of two, 2..8
- WIDTH, 32, operand width in bits
- clk  input  1  sole clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  N_REQ  request per requester; held high with operands stable until ack
- a_bus  input  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- b_bus  input  N_REQ*WIDTH  operand B, same packing
- ack  output  N_REQ  one-hot, one-cycle completion pulse to the served requester
- lt  output  1  A < B (signed two's-complement), valid while ack is nonzero
- gt  output  1  A > B (signed), valid while ack is nonzero
- eq  output  1  A == B, present only with CMP_SHARE_EQ_EN
- gnt_id  output  log2(N_REQ)  index of the requester currently owning the comparator
- busy  output  1  high in LOAD and RESP states

## Operation
- FSM states: IDLE, LOAD, RESP. Encoding is shared through the package.
- IDLE: if any req bit is set, the round-robin pick wins. Its operands are latched into a_q/b_q, gnt_id is set to the winner, and the next state is LOAD. Otherwise the FSM stays in IDLE.
- LOAD: the comparator evaluates a_q, b_q. lt_q, gt_q (and eq_q) are registered, ack[gnt_id] is set, and the next state is RESP.
- RESP: ack is high for exactly this cycle. On exit, ack is cleared, the pointer moves to gnt_id+1 (mod N_REQ), and the next state is IDLE.
- Round-robin: search starts at the pointer and wraps. The winner is the first set req bit at or after the pointer. Pointer resets to 0.
- Compare arithmetic:
  - diff = a_q - b_q, computed in WIDTH+1 bits via sign extension. lt = diff[WIDTH], which is overflow-correct.
  - gt is the same computation with operands swapped.
  - lt and gt are never both 1.
  - Equal operands give lt=gt=0.
- req sampling happens only in IDLE. req changes in LOAD/RESP are ignored. Dropping req early does not cancel the transaction; ack is still issued.
- A requester must deassert req on the clock edge at which it sees ack=1. A req still high in the following IDLE cycle is a new request.
- Simultaneous requests: exactly one is granted per transaction; the others wait. With all N_REQ requesting continuously, each is served once every 3*N_REQ cycles.

## Timing
- Latency: req high in IDLE at edge k → LOAD after k → ack/lt/gt valid after edge k+1, for one cycle → IDLE after k+2.
- Throughput: one compare per 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values (rst_n low, immediate, asynchronous): state IDLE, ack=0, lt=0, gt=0, eq=0, gnt_id=0, busy=0, pointer 0, a_q=b_q=0.
- Reset mid-transaction aborts it with no ack. The first request after rst_n rises is arbitrated from pointer 0.

## Configuration
- CMP_SHARE_EQ_EN defined:
  - Port eq and register eq_q exist.
  - eq = (a_q == b_q), registered in LOAD with lt/gt.
  - eq resets to 0.
- Undefined: eq port and logic are absent. lt=gt=0 is the only indication of equality.

## Structure
- Shared package/header cmp_share_pkg holds:
  - FSM state constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RESP=2'd2
  - default widths
  - a log2 helper for gnt_id width
- Sub-module rr_arb: combinational pick from req and pointer, giving a one-hot grant and a binary index. It is parameterised by N_REQ.
- The comparator core is instantiated twice inside cmp_share_arb, using the team's 32-bit add/sub unit in subtract mode for A-B and B-A. Overflow correction is applied on top.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → ack=0, lt=gt=0, busy=0, gnt_id=0. Release rst_n → req0 is served first, ack=4'b0001 exactly 2 cycles later.
- Single request: req[2] with A=5, B=9 → ack=4'b0100 after 2 edges, lt=1, gt=0. Then A=-3, B=2 gives lt=1. A=0x7FFFFFFF, B=0x80000000 gives gt=1, lt=0 (overflow case).
- Equality: A=B=0x12345678 → lt=gt=0; eq=1 with CMP_SHARE_EQ_EN.
- Fairness: all four req held, each dropping for one cycle after its ack → ack order 0,1,2,3,0; acks spaced 3 cycles apart.
- Wrap/pointer: serve req3, then assert req0 and req3 together → req0 is granted first.
- Mid-transaction reset: req[1] with A=1, B=2, pulse rst_n low during LOAD → no ack ever issued; all outputs return to 0 asynchronously.
